decode_stage_pipelined: RTL and testbench

//  Parametrised, pipelined successor of the single-cycle decode stage.
//  - Contains a register file with write-to-read bypass and opcode-dependent immediate extension.
//  - Detects load-use hazards and stalls the front end for one cycle.
//  - Registers all decode results into an ID/EX pipeline register that supports valid, bubble and flush.
//  - Replaces the in-decode JAL link write: the link value travels down the pipe instead.
//  - Sits between the IF/ID register and the execute stage.

---
 rtl/decode_pkg.sv | 37 +++
 rtl/reg_file_bypass.sv | 51 +++++
 rtl/decode_stage_pipelined.sv | 168 ++++++++++++++++
 tb/tb_decode_stage_pipelined.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared constants for the pipelined decode stage: control bundle layout,
// immediate-extension opcodes and link defaults.
package decode_pkg;

  localparam int CTRL_W = 20;

  // Bit offsets of the packed control bundle driven by the Controller
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_JUMP       = 7;
  localparam int CTRL_ALU_OP_LSB = 8;
  localparam int CTRL_ALU_OP_W   = 6;
  localparam int CTRL_MEM_SZ_LSB = 14;
  localparam int CTRL_MEM_SZ_W   = 2;
  localparam int CTRL_MOVE_LSB   = 16;
  localparam int CTRL_MOVE_W     = 2;
  localparam int CTRL_EXT_LSB    = 18;
  localparam int CTRL_EXT_W      = 2;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  localparam int LINK_REG_DEFAULT = 31;
  localparam int PC_INC_DEFAULT   = 4;

  // Logical immediates are zero-extended; everything else sign-extends
  function automatic logic is_zero_ext(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Two-read, one-write register file with hardwired zero register and
// same-cycle write-to-read bypass.
module reg_file_bypass #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              commit;

  assign commit = wr_en && (wr_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (commit && ({1'b0, wr_addr} < (REG_AW+1)'(NUM_REGS)))
      regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] addr);
    if (addr == '0)
      return '0;
    if (commit && (wr_addr == addr))
      return wr_data;
    if ({1'b0, addr} < (REG_AW+1)'(NUM_REGS))
      return regs_q[addr];
    return '0;
  endfunction

  always_comb begin
    rd_data1 = read_port(rd_addr1);
    rd_data2 = read_port(rd_addr2);
  end

endmodule

// File: rtl/decode_stage_pipelined.sv
// Pipelined decode stage: register read with bypass, load-use stall,
// immediate extension and the ID/EX register with bubble/flush support.
module decode_stage_pipelined
  import decode_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = LINK_REG_DEFAULT,
  parameter int PC_INC   = PC_INC_DEFAULT,
  parameter int CTRL_W   = decode_pkg::CTRL_W,
  parameter int CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              IfValid,
  input  logic [31:0]       Instruction,
  input  logic [DATA_W-1:0] PCResult,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic              JumpAndLink,
  input  logic              WbRegWrite,
  input  logic              WbMove,
  input  logic [REG_AW-1:0] WbWriteRegister,
  input  logic [DATA_W-1:0] WbWriteData,
  input  logic              ExMemRead,
  input  logic [REG_AW-1:0] ExRt,
  input  logic              Flush,
  output logic              IdReady,
  output logic              ExValid,
  output logic [CTRL_W-1:0] ExCtrl,
  output logic [DATA_W-1:0] ExReadData1,
  output logic [DATA_W-1:0] ExReadData2,
  output logic [DATA_W-1:0] ExImm,
  output logic [REG_AW-1:0] ExRs,
  output logic [REG_AW-1:0] ExRtOut,
  output logic [REG_AW-1:0] ExRd,
  output logic              ExLinkWrite,
  output logic [DATA_W-1:0] ExLinkData,
  output logic [CNT_W-1:0]  StallCount
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              stall;

  assign opcode = Instruction[31:26];
  assign rs     = REG_AW'(Instruction[25:21]);
  assign rt     = REG_AW'(Instruction[20:16]);
  assign rd     = REG_AW'(Instruction[15:11]);
  assign imm16  = Instruction[15:0];

  reg_file_bypass #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .REG_AW  (REG_AW)
  ) u_reg_file (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .wr_en   (WbRegWrite && WbMove),
    .wr_addr (WbWriteRegister),
    .wr_data (WbWriteData),
    .rd_addr1(rs),
    .rd_addr2(rt),
    .rd_data1(rd_data1),
    .rd_data2(rd_data2)
  );

  // rt is compared even for I-type forms where it is a destination: cheap and safe
  assign stall = Reset_n && IfValid && ExMemRead && (ExRt != '0) &&
                 ((ExRt == rs) || (ExRt == rt));
  assign IdReady = !stall;

  always_comb begin
    if (is_zero_ext(opcode)) imm_ext = {{(DATA_W-16){1'b0}}, imm16};
    else                     imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
  end

  logic              ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d;
  logic [DATA_W-1:0] ex_rd2_q, ex_rd2_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_link_write_q, ex_link_write_d;
  logic [DATA_W-1:0] ex_link_data_q, ex_link_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_ctrl_d       = ex_ctrl_q;
    ex_rd1_d        = ex_rd1_q;
    ex_rd2_d        = ex_rd2_q;
    ex_imm_d        = ex_imm_q;
    ex_rs_d         = ex_rs_q;
    ex_rt_d         = ex_rt_q;
    ex_rd_d         = ex_rd_q;
    ex_link_write_d = ex_link_write_q;
    ex_link_data_d  = ex_link_data_q;

    // Flush and bubble zero only the qualifying fields; data may go stale
    if (Flush || stall || !IfValid) begin
      ex_valid_d      = 1'b0;
      ex_ctrl_d       = '0;
      ex_link_write_d = 1'b0;
    end else begin
      ex_valid_d      = 1'b1;
      ex_ctrl_d       = CtrlIn;
      ex_rd1_d        = rd_data1;
      ex_rd2_d        = rd_data2;
      ex_imm_d        = imm_ext;
      ex_rs_d         = rs;
      ex_rt_d         = rt;
      ex_rd_d         = rd;
      ex_link_write_d = JumpAndLink && (LINK_REG != 0);
      ex_link_data_d  = PCResult + DATA_W'(PC_INC);
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ex_valid_q      <= 1'b0;
      ex_ctrl_q       <= '0;
      ex_rd1_q        <= '0;
      ex_rd2_q        <= '0;
      ex_imm_q        <= '0;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_rd_q         <= '0;
      ex_link_write_q <= 1'b0;
      ex_link_data_q  <= '0;
      stall_cnt_q     <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_ctrl_q       <= ex_ctrl_d;
      ex_rd1_q        <= ex_rd1_d;
      ex_rd2_q        <= ex_rd2_d;
      ex_imm_q        <= ex_imm_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_rd_q         <= ex_rd_d;
      ex_link_write_q <= ex_link_write_d;
      ex_link_data_q  <= ex_link_data_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign ExValid     = ex_valid_q;
  assign ExCtrl      = ex_ctrl_q;
  assign ExReadData1 = ex_rd1_q;
  assign ExReadData2 = ex_rd2_q;
  assign ExImm       = ex_imm_q;
  assign ExRs        = ex_rs_q;
  assign ExRtOut     = ex_rt_q;
  assign ExRd        = ex_rd_q;
  assign ExLinkWrite = ex_link_write_q;
  assign ExLinkData  = ex_link_data_q;
  assign StallCount  = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Scoreboard bench for decode_stage_pipelined: a reference register model
// predicts each ID/EX entry, which is queued and checked one edge later.
module tb_decode_stage_pipelined;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        Clk, Reset_n;
  logic        IfValid;
  logic [31:0] Instruction, PCResult;
  logic [19:0] CtrlIn;
  logic        JumpAndLink, WbRegWrite, WbMove;
  logic [4:0]  WbWriteRegister;
  logic [31:0] WbWriteData;
  logic        ExMemRead;
  logic [4:0]  ExRt;
  logic        Flush;
  logic        IdReady, ExValid;
  logic [19:0] ExCtrl;
  logic [31:0] ExReadData1, ExReadData2, ExImm;
  logic [4:0]  ExRs, ExRtOut, ExRd;
  logic        ExLinkWrite;
  logic [31:0] ExLinkData;
  logic [CNT_W-1:0] StallCount;

  decode_stage_pipelined #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .IfValid(IfValid), .Instruction(Instruction),
    .PCResult(PCResult), .CtrlIn(CtrlIn), .JumpAndLink(JumpAndLink),
    .WbRegWrite(WbRegWrite), .WbMove(WbMove), .WbWriteRegister(WbWriteRegister),
    .WbWriteData(WbWriteData), .ExMemRead(ExMemRead), .ExRt(ExRt), .Flush(Flush),
    .IdReady(IdReady), .ExValid(ExValid), .ExCtrl(ExCtrl),
    .ExReadData1(ExReadData1), .ExReadData2(ExReadData2), .ExImm(ExImm),
    .ExRs(ExRs), .ExRtOut(ExRtOut), .ExRd(ExRd), .ExLinkWrite(ExLinkWrite),
    .ExLinkData(ExLinkData), .StallCount(StallCount)
  );

  typedef struct {
    logic        valid;
    logic [19:0] ctrl;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        lw;
    logic [31:0] ld;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [32];
  int          exp_cnt;
  int          total, bad;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WbRegWrite && WbMove && WbWriteRegister == a) return WbWriteData;
    return m_regs[a];
  endfunction

  task automatic set_instr(input logic iv, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [15:0] imm,
                           input logic [31:0] pc, input logic [19:0] ctrl, input logic jal);
    IfValid     = iv;
    Instruction = {op, rs, rt, imm};
    PCResult    = pc;
    CtrlIn      = ctrl;
    JumpAndLink = jal;
  endtask

  task automatic set_wb(input logic we, input logic mv, input logic [4:0] a, input logic [31:0] d);
    WbRegWrite = we; WbMove = mv; WbWriteRegister = a; WbWriteData = d;
  endtask

  task automatic set_hz(input logic mr, input logic [4:0] rt, input logic fl);
    ExMemRead = mr; ExRt = rt; Flush = fl;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    exp_cnt = 0;
    sb.delete();
  endtask

  // Predict, clock once, then pop and compare the ID/EX entry
  task automatic cycle(input string tag);
    exp_t        e;
    logic [4:0]  rs, rt;
    logic [5:0]  op;
    logic        stall_m, commit;
    #1;
    op = Instruction[31:26];
    rs = Instruction[25:21];
    rt = Instruction[20:16];
    stall_m = IfValid && ExMemRead && (ExRt != 5'd0) && ((ExRt == rs) || (ExRt == rt));
    total++;
    if (IdReady !== !stall_m) begin
      bad++;
      $display("FAIL %s IdReady got=%0b want=%0b", tag, IdReady, !stall_m);
    end
    commit  = WbRegWrite && WbMove && (WbWriteRegister != 5'd0);
    e.valid = IfValid && !stall_m && !Flush;
    e.ctrl  = e.valid ? CtrlIn : 20'd0;
    e.rd1   = m_read(rs);
    e.rd2   = m_read(rt);
    e.imm   = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'd0, Instruction[15:0]}
                                                          : {{16{Instruction[15]}}, Instruction[15:0]};
    e.rs    = rs;
    e.rt    = rt;
    e.rd    = Instruction[15:11];
    e.lw    = e.valid && JumpAndLink;
    e.ld    = PCResult + 32'd4;
    sb.push_back(e);
    @(posedge Clk);
    if (commit) m_regs[WbWriteRegister] = WbWriteData;
    if (stall_m && exp_cnt < CNT_MAX) exp_cnt++;
    #1;
    e = sb.pop_front();
    total += 4;
    if (ExValid !== e.valid) begin
      bad++; $display("FAIL %s ExValid got=%0b want=%0b", tag, ExValid, e.valid);
    end
    if (ExCtrl !== e.ctrl) begin
      bad++; $display("FAIL %s ExCtrl got=%0h want=%0h", tag, ExCtrl, e.ctrl);
    end
    if (ExLinkWrite !== e.lw) begin
      bad++; $display("FAIL %s ExLinkWrite got=%0b want=%0b", tag, ExLinkWrite, e.lw);
    end
    if (StallCount !== CNT_W'(exp_cnt)) begin
      bad++; $display("FAIL %s StallCount got=%0d want=%0d", tag, StallCount, exp_cnt);
    end
    if (e.valid) begin
      total += 7;
      if (ExReadData1 !== e.rd1) begin
        bad++; $display("FAIL %s ExReadData1 got=%0h want=%0h", tag, ExReadData1, e.rd1);
      end
      if (ExReadData2 !== e.rd2) begin
        bad++; $display("FAIL %s ExReadData2 got=%0h want=%0h", tag, ExReadData2, e.rd2);
      end
      if (ExImm !== e.imm) begin
        bad++; $display("FAIL %s ExImm got=%0h want=%0h", tag, ExImm, e.imm);
      end
      if (ExRs !== e.rs) begin
        bad++; $display("FAIL %s ExRs got=%0d want=%0d", tag, ExRs, e.rs);
      end
      if (ExRtOut !== e.rt) begin
        bad++; $display("FAIL %s ExRtOut got=%0d want=%0d", tag, ExRtOut, e.rt);
      end
      if (ExRd !== e.rd) begin
        bad++; $display("FAIL %s ExRd got=%0d want=%0d", tag, ExRd, e.rd);
      end
      if (e.lw && ExLinkData !== e.ld) begin
        bad++; $display("FAIL %s ExLinkData got=%0h want=%0h", tag, ExLinkData, e.ld);
      end
    end
  endtask

  task automatic idle_inputs();
    set_instr(1'b0, 6'h00, 5'd0, 5'd0, 16'h0, 32'h0, 20'h0, 1'b0);
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    set_hz(1'b0, 5'd0, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    total += 6;
    if (ExValid !== 1'b0)    begin bad++; $display("FAIL %s ExValid got=%0b want=0", tag, ExValid); end
    if (IdReady !== 1'b1)    begin bad++; $display("FAIL %s IdReady got=%0b want=1", tag, IdReady); end
    if (ExCtrl !== 20'd0)    begin bad++; $display("FAIL %s ExCtrl got=%0h want=0", tag, ExCtrl); end
    if (ExReadData1 !== 32'd0) begin bad++; $display("FAIL %s ExReadData1 got=%0h want=0", tag, ExReadData1); end
    if (ExLinkData !== 32'd0 || ExLinkWrite !== 1'b0) begin
      bad++; $display("FAIL %s ExLink got=%0b/%0h want=0/0", tag, ExLinkWrite, ExLinkData);
    end
    if (StallCount !== '0)   begin bad++; $display("FAIL %s StallCount got=%0d want=0", tag, StallCount); end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    idle_inputs();
    clear_model();
    #3;
    check_cleared("reset_initial");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_bypass();
    set_instr(1'b1, 6'h00, 5'd5, 5'd0, 16'h2820, 32'h100, 20'h00001, 1'b0);
    set_wb(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle("bypass_r5");
    set_wb(1'b1, 1'b1, 5'd9, 32'h12345678);
    set_instr(1'b1, 6'h00, 5'd9, 5'd5, 16'h4820, 32'h104, 20'h00011, 1'b0);
    cycle("bypass_rt_stored");
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset_midstream();
    set_instr(1'b1, 6'h00, 5'd5, 5'd9, 16'h1820, 32'h200, 20'hABCDE, 1'b1);
    cycle("pre_reset");
    set_hz(1'b1, 5'd7, 1'b0);
    set_instr(1'b1, 6'h00, 5'd5, 5'd7, 16'h1820, 32'h204, 20'hABCDE, 1'b0);
    #2;
    Reset_n = 1'b0;
    #1;
    check_cleared("reset_midstream");
    clear_model();
    idle_inputs();
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    set_instr(1'b1, 6'h00, 5'd5, 5'd9, 16'h0, 32'h300, 20'h00002, 1'b0);
    cycle("read_after_reset");
  endtask

  task automatic test_load_use_stall();
    set_hz(1'b1, 5'd7, 1'b0);
    set_instr(1'b1, 6'h23, 5'd2, 5'd7, 16'h0004, 32'h400, 20'h0000A, 1'b0);
    cycle("stall_rt");
    set_hz(1'b0, 5'd7, 1'b0);
    cycle("stall_release");
    set_hz(1'b1, 5'd3, 1'b0);
    set_instr(1'b1, 6'h00, 5'd3, 5'd1, 16'h1020, 32'h404, 20'h0000B, 1'b0);
    cycle("stall_rs");
    set_hz(1'b1, 5'd0, 1'b0);
    set_instr(1'b1, 6'h00, 5'd0, 5'd0, 16'h1020, 32'h408, 20'h0000C, 1'b0);
    cycle("no_stall_r0");
    set_hz(1'b1, 5'd3, 1'b0);
    set_instr(1'b0, 6'h00, 5'd3, 5'd3, 16'h1020, 32'h40C, 20'h0000D, 1'b0);
    cycle("no_stall_invalid");
    set_hz(1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_flush();
    set_instr(1'b1, 6'h00, 5'd1, 5'd2, 16'h1820, 32'h500, 20'hFFFFF, 1'b1);
    set_hz(1'b0, 5'd0, 1'b1);
    cycle("flush_valid");
    set_hz(1'b1, 5'd2, 1'b1);
    cycle("flush_with_stall");
    set_hz(1'b0, 5'd0, 1'b0);
    cycle("flush_represent");
  endtask

  task automatic test_jal();
    set_instr(1'b1, 6'h03, 5'd0, 5'd0, 16'hF800, 32'h0040_0010, 20'h00080, 1'b1);
    cycle("jal_link");
    set_instr(1'b1, 6'h03, 5'd0, 5'd0, 16'hF800, 32'hFFFF_FFFC, 20'h00080, 1'b1);
    cycle("jal_wrap");
    total++;
    if (ExLinkData !== 32'd0) begin
      bad++; $display("FAIL jal_wrap_zero ExLinkData got=%0h want=0", ExLinkData);
    end
  endtask

  task automatic test_imm();
    logic [5:0] ops [5];
    ops = '{6'h0D, 6'h08, 6'h0C, 6'h0E, 6'h23};
    foreach (ops[i]) begin
      set_instr(1'b1, ops[i], 5'd1, 5'd4, 16'h8000, 32'h600, 20'h00010, 1'b0);
      cycle($sformatf("imm_op%0h_8000", ops[i]));
      set_instr(1'b1, ops[i], 5'd1, 5'd4, 16'h7FFF, 32'h604, 20'h00010, 1'b0);
      cycle($sformatf("imm_op%0h_7fff", ops[i]));
    end
  endtask

  task automatic test_r0_and_move();
    set_wb(1'b1, 1'b1, 5'd0, 32'h1234_5678);
    set_instr(1'b1, 6'h00, 5'd0, 5'd0, 16'h0, 32'h700, 20'h00001, 1'b0);
    cycle("r0_write_bypass");
    set_wb(1'b1, 1'b1, 5'd3, 32'h0000_0033);
    cycle("r0_after");
    set_wb(1'b1, 1'b0, 5'd3, 32'h0000_0099);
    set_instr(1'b1, 6'h00, 5'd3, 5'd0, 16'h0, 32'h704, 20'h00001, 1'b0);
    cycle("move0_no_bypass");
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    cycle("move0_unchanged");
  endtask

  task automatic test_back_to_back();
    logic [5:0] op_list [6];
    op_list = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23};
    for (int n = 0; n < 80; n++) begin
      set_instr(($urandom_range(7) != 0), op_list[$urandom_range(5)],
                5'($urandom_range(7)), 5'($urandom_range(7)), 16'($urandom),
                $urandom, 20'($urandom), ($urandom_range(7) == 0));
      set_wb($urandom_range(1), ($urandom_range(3) != 0), 5'($urandom_range(7)), $urandom);
      set_hz(($urandom_range(3) == 0), 5'($urandom_range(7)), ($urandom_range(7) == 0));
      cycle($sformatf("b2b_%0d", n));
    end
    idle_inputs();
  endtask

  task automatic test_stall_saturate();
    set_hz(1'b1, 5'd6, 1'b0);
    set_instr(1'b1, 6'h00, 5'd6, 5'd1, 16'h0, 32'h800, 20'h00001, 1'b0);
    for (int n = 0; n < CNT_MAX + 4; n++) cycle($sformatf("sat_%0d", n));
    total++;
    if (StallCount !== CNT_W'(CNT_MAX)) begin
      bad++; $display("FAIL stall_saturated StallCount got=%0d want=%0d", StallCount, CNT_MAX);
    end
    set_hz(1'b0, 5'd0, 1'b0);
    cycle("sat_release");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_bypass();
    test_reset_midstream();
    test_load_use_stall();
    test_flush();
    test_jal();
    test_imm();
    test_r0_and_move();
    test_back_to_back();
    test_stall_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
